// File: rtl/decode_queue_pkg.sv
// Shared constants, slot record and length-decode helper for the decode queue.
package decode_queue_pkg;

  localparam int          FETCH_HALVES_DEF = 2;
  localparam int          DEPTH_DEF        = 8;
  localparam int          ISSUE_DEF        = 1;
  localparam logic [31:0] RESET_PC_DEF     = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        error;
  } decode_queue_slot_type;

  // A halfword whose two low bits are set opens a 32-bit instruction.
  function automatic logic hw_is_32(input logic [15:0] hw);
    return (hw[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and issue-side handshake bundle of the decode queue.
interface decode_queue_if
  import decode_queue_pkg::*;
#(
  parameter int FETCH_HALVES = FETCH_HALVES_DEF,
  parameter int ISSUE        = ISSUE_DEF
);
  logic                      clear;
  logic [31:0]               clear_pc;
  logic                      fetch_valid;
  logic                      fetch_ready;
  logic [16*FETCH_HALVES-1:0] fetch_data;
  logic                      fetch_error;
  logic [ISSUE-1:0]          instr_valid;
  logic [32*ISSUE-1:0]       instr;
  logic [32*ISSUE-1:0]       instr_pc;
  logic [32*ISSUE-1:0]       instr_npc;
  logic [ISSUE-1:0]          instr_error;
  logic [ISSUE-1:0]          take;

  modport master (
    output clear, clear_pc, fetch_valid, fetch_data, fetch_error, take,
    input  fetch_ready, instr_valid, instr, instr_pc, instr_npc, instr_error
  );

  modport slave (
    input  clear, clear_pc, fetch_valid, fetch_data, fetch_error, take,
    output fetch_ready, instr_valid, instr, instr_pc, instr_npc, instr_error
  );
endinterface

// File: rtl/decode_queue_slot.sv
// Extracts one issue slot from the two halfwords at its start position.
module decode_queue_slot
  import decode_queue_pkg::*;
#(
  parameter int PW = 4
) (
  input  logic [15:0]           hw0,
  input  logic [15:0]           hw1,
  input  logic                  err0,
  input  logic                  err1,
  input  logic [PW-1:0]         avail,
  input  logic [31:0]           pc,
  output decode_queue_slot_type slot,
  output logic                  is32
);

  logic err_s;
  logic long_s;

  // Length decode, completeness and fault folding for this slot.
  always_comb begin
    long_s     = hw_is_32(hw0) & ~err0;
    err_s      = err0 | (long_s & err1);
    is32       = long_s;
    slot.valid = long_s ? (avail >= PW'(2)) : (avail >= PW'(1));
    slot.error = err_s;
    if (err_s) begin
      slot.instr = 32'h0000_0000;
    end else if (long_s) begin
      slot.instr = {hw1, hw0};
    end else begin
      slot.instr = {16'h0000, hw0};
    end
    slot.pc  = pc & 32'hFFFF_FFFE;
    slot.npc = (pc & 32'hFFFF_FFFE) + (long_s ? 32'd4 : 32'd2);
  end

endmodule

// File: rtl/decode_queue.sv
// Halfword queue between fetch and decode: stores fetch beats and presents
// up to ISSUE length-decoded instructions per cycle with their PCs.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int          FETCH_HALVES = FETCH_HALVES_DEF,
  parameter int          DEPTH        = DEPTH_DEF,
  parameter int          ISSUE        = ISSUE_DEF,
  parameter logic [31:0] RESET_PC     = RESET_PC_DEF
) (
  input  logic            clock,
  input  logic            reset,
  decode_queue_if.slave   bus
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int FHW = $clog2(FETCH_HALVES);

  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [DEPTH-1:0] err_q, err_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   pc_q, pc_d;
  logic [FHW-1:0] discard_q, discard_d;

  logic [PW-1:0] count_s, free_s, consumed_s, written_s, idx0_b_s;
  logic          fetch_ready_s, accept_s, take0_s, take1_s;
  logic          slot0_is32_s, slot1_is32_s;
  decode_queue_slot_type slot0_s, slot1_s, sel_s;

  assign count_s       = wr_ptr_q - rd_ptr_q;
  assign free_s        = PW'(DEPTH) - count_s;
  assign written_s     = PW'(FETCH_HALVES) - PW'(discard_q);
  assign fetch_ready_s = reset & ~bus.clear & (free_s >= PW'(FETCH_HALVES));
  assign accept_s      = bus.fetch_valid & fetch_ready_s;
  assign idx0_b_s      = rd_ptr_q + PW'(1);

  decode_queue_slot #(.PW(PW)) u_slot0 (
    .hw0   (mem_q[rd_ptr_q[AW-1:0]]),
    .hw1   (mem_q[idx0_b_s[AW-1:0]]),
    .err0  (err_q[rd_ptr_q[AW-1:0]]),
    .err1  (err_q[idx0_b_s[AW-1:0]]),
    .avail (count_s),
    .pc    (pc_q),
    .slot  (slot0_s),
    .is32  (slot0_is32_s)
  );

  if (ISSUE == 2) begin : g_slot1
    logic [PW-1:0] start_s, idx_a_s, idx_b_s, avail_s;
    assign start_s = slot0_is32_s ? PW'(2) : PW'(1);
    assign idx_a_s = rd_ptr_q + start_s;
    assign idx_b_s = idx_a_s + PW'(1);
    // Slot 1 sees nothing unless slot 0 is complete.
    assign avail_s = slot0_s.valid ? (count_s - start_s) : PW'(0);

    decode_queue_slot #(.PW(PW)) u_slot1 (
      .hw0   (mem_q[idx_a_s[AW-1:0]]),
      .hw1   (mem_q[idx_b_s[AW-1:0]]),
      .err0  (err_q[idx_a_s[AW-1:0]]),
      .err1  (err_q[idx_b_s[AW-1:0]]),
      .avail (avail_s),
      .pc    (slot0_s.npc),
      .slot  (slot1_s),
      .is32  (slot1_is32_s)
    );
  end else begin : g_no_slot1
    assign slot1_s      = '0;
    assign slot1_is32_s = 1'b0;
  end

  // Only a valid prefix of take counts; everything else is ignored.
  always_comb begin
    take0_s = bus.take[0] & slot0_s.valid;
    take1_s = (ISSUE == 2) && bus.take[ISSUE-1] && take0_s && slot1_s.valid;
    if (take0_s) begin
      consumed_s = slot0_is32_s ? PW'(2) : PW'(1);
    end else begin
      consumed_s = PW'(0);
    end
    if (take1_s) begin
      consumed_s = consumed_s + (slot1_is32_s ? PW'(2) : PW'(1));
    end else begin
      consumed_s = consumed_s;
    end
  end

  // Next-state: clear wins over dequeue and enqueue in the same cycle.
  always_comb begin
    mem_d     = mem_q;
    err_d     = err_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    if (bus.clear) begin
      rd_ptr_d  = wr_ptr_q;
      pc_d      = bus.clear_pc & 32'hFFFF_FFFE;
      discard_d = bus.clear_pc[FHW:1];
    end else begin
      rd_ptr_d = rd_ptr_q + consumed_s;
      pc_d     = pc_q + 32'({consumed_s, 1'b0});
      if (accept_s) begin
        // Leading halfwords below the discard count are dropped; the rest pack from wr_ptr.
        for (int i = 0; i < FETCH_HALVES; i++) begin
          mem_d[AW'(wr_ptr_q + PW'(i) - PW'(discard_q))] =
            (FHW'(i) >= discard_q) ? bus.fetch_data[16*i +: 16]
                                   : mem_d[AW'(wr_ptr_q + PW'(i) - PW'(discard_q))];
          err_d[AW'(wr_ptr_q + PW'(i) - PW'(discard_q))] =
            (FHW'(i) >= discard_q) ? bus.fetch_error
                                   : err_d[AW'(wr_ptr_q + PW'(i) - PW'(discard_q))];
        end
        wr_ptr_d  = wr_ptr_q + written_s;
        discard_d = '0;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pc_q      <= RESET_PC;
      discard_q <= RESET_PC[FHW:1];
      err_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      err_q     <= err_d;
    end
  end

  // Halfword data storage, deliberately not reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Pack slot records onto the issue bus.
  always_comb begin
    bus.fetch_ready = fetch_ready_s;
    bus.instr_valid = '0;
    bus.instr       = '0;
    bus.instr_pc    = '0;
    bus.instr_npc   = '0;
    bus.instr_error = '0;
    sel_s           = '0;
    for (int k = 0; k < ISSUE; k++) begin
      sel_s                    = (k == 0) ? slot0_s : slot1_s;
      bus.instr_valid[k]       = sel_s.valid & reset;
      bus.instr[32*k +: 32]    = sel_s.instr;
      bus.instr_pc[32*k +: 32] = sel_s.pc;
      bus.instr_npc[32*k +: 32] = sel_s.npc;
      bus.instr_error[k]       = sel_s.error;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed, table-driven bench for decode_queue (FETCH_HALVES=2, DEPTH=8, ISSUE=2).
module tb_decode_queue;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  decode_queue_if #(.FETCH_HALVES(2), .ISSUE(2)) bus ();

  decode_queue #(
    .FETCH_HALVES (2),
    .DEPTH        (8),
    .ISSUE        (2),
    .RESET_PC     (32'h0000_0000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        clr;
    logic [31:0] cpc;
    logic        fv;
    logic [31:0] fd;
    logic        fe;
    logic [1:0]  tk;
    logic [1:0]  ev;
    logic [31:0] ei0;
    logic [31:0] ep0;
    logic [31:0] en0;
    logic        ee0;
    logic        ci0;
    logic [31:0] ei1;
    logic [31:0] ep1;
    logic        ee1;
    logic        er;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.clear       = 1'b0;
    bus.clear_pc    = 32'h0000_0000;
    bus.fetch_valid = 1'b0;
    bus.fetch_data  = 32'h0000_0000;
    bus.fetch_error = 1'b0;
    bus.take        = 2'b00;
  endtask

  function automatic void add(input logic clr, input logic [31:0] cpc, input logic fv,
                              input logic [31:0] fd, input logic fe, input logic [1:0] tk,
                              input logic [1:0] ev, input logic [31:0] ei0, input logic [31:0] ep0,
                              input logic [31:0] en0, input logic ee0, input logic ci0,
                              input logic [31:0] ei1, input logic [31:0] ep1, input logic ee1,
                              input logic er);
    vec_t v;
    v = '{clr, cpc, fv, fd, fe, tk, ev, ei0, ep0, en0, ee0, ci0, ei1, ep1, ee1, er};
    vq.push_back(v);
  endfunction

  task automatic beat(input logic [31:0] d);
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = d;
    @(posedge clock);
    #1;
    idle();
    #1;
  endtask

  initial begin
    //  clr cpc           fv fd             fe tk     ev     ei0            ep0           en0           ee0 ci0 ei1          ep1           ee1 er
    add(0, 32'h0,       1, 32'h00000513, 0, 2'b00, 2'b01, 32'h00000513, 32'h0,   32'h4,   0, 1, 32'h0,      32'h0,   0, 1);
    add(0, 32'h0,       1, 32'h00130013, 0, 2'b01, 2'b01, 32'h00130013, 32'h4,   32'h8,   0, 1, 32'h0,      32'h0,   0, 1);
    add(0, 32'h0,       0, 32'h0,        0, 2'b01, 2'b00, 32'h0,        32'h8,   32'h0,   0, 0, 32'h0,      32'h0,   0, 1);
    add(0, 32'h0,       1, 32'h45014081, 0, 2'b00, 2'b11, 32'h00004081, 32'h8,   32'hA,   0, 1, 32'h4501,   32'hA,   0, 1);
    add(0, 32'h0,       0, 32'h0,        0, 2'b10, 2'b11, 32'h00004081, 32'h8,   32'hA,   0, 1, 32'h4501,   32'hA,   0, 1);
    add(0, 32'h0,       0, 32'h0,        0, 2'b11, 2'b00, 32'h0,        32'hC,   32'h0,   0, 0, 32'h0,      32'h0,   0, 1);
    add(0, 32'h0,       1, 32'h00930001, 0, 2'b00, 2'b01, 32'h00000001, 32'hC,   32'hE,   0, 1, 32'h0,      32'h0,   0, 1);
    add(0, 32'h0,       0, 32'h0,        0, 2'b01, 2'b00, 32'h0,        32'hE,   32'h0,   0, 0, 32'h0,      32'h0,   0, 1);
    add(0, 32'h0,       1, 32'h00010010, 0, 2'b00, 2'b11, 32'h00100093, 32'hE,   32'h12,  0, 1, 32'h0001,   32'h12,  0, 1);
    add(0, 32'h0,       0, 32'h0,        0, 2'b11, 2'b00, 32'h0,        32'h14,  32'h0,   0, 0, 32'h0,      32'h0,   0, 1);
    add(0, 32'h0,       1, 32'h05134081, 0, 2'b00, 2'b01, 32'h00004081, 32'h14,  32'h16,  0, 1, 32'h0,      32'h0,   0, 1);
    add(0, 32'h0,       1, 32'h12340000, 0, 2'b01, 2'b11, 32'h00000513, 32'h16,  32'h1A,  0, 1, 32'h1234,   32'h1A,  0, 1);
    add(0, 32'h0,       0, 32'h0,        0, 2'b11, 2'b00, 32'h0,        32'h1C,  32'h0,   0, 0, 32'h0,      32'h0,   0, 1);
    add(1, 32'h102,     0, 32'h0,        0, 2'b00, 2'b00, 32'h0,        32'h102, 32'h0,   0, 0, 32'h0,      32'h0,   0, 1);
    add(0, 32'h0,       1, 32'h00014501, 0, 2'b00, 2'b01, 32'h00000001, 32'h102, 32'h104, 0, 1, 32'h0,      32'h0,   0, 1);
    add(0, 32'h0,       1, 32'h00020003, 0, 2'b00, 2'b11, 32'h00000001, 32'h102, 32'h104, 0, 1, 32'h00020003, 32'h104, 0, 1);
    add(1, 32'h201,     1, 32'hFFFFFFFF, 0, 2'b11, 2'b00, 32'h0,        32'h200, 32'h0,   0, 0, 32'h0,      32'h0,   0, 1);
    add(0, 32'h0,       1, 32'h05130013, 1, 2'b00, 2'b11, 32'h0,        32'h200, 32'h202, 1, 1, 32'h0,      32'h202, 1, 1);
    add(0, 32'h0,       0, 32'h0,        0, 2'b11, 2'b00, 32'h0,        32'h204, 32'h0,   0, 0, 32'h0,      32'h0,   0, 1);
    add(0, 32'h0,       1, 32'h00030001, 0, 2'b00, 2'b01, 32'h00000001, 32'h204, 32'h206, 0, 1, 32'h0,      32'h0,   0, 1);
    add(0, 32'h0,       1, 32'hAAABBBBB, 1, 2'b01, 2'b11, 32'h0,        32'h206, 32'h20A, 1, 0, 32'h0,      32'h20A, 1, 1);
    add(0, 32'h0,       0, 32'h0,        0, 2'b11, 2'b00, 32'h0,        32'h20C, 32'h0,   0, 0, 32'h0,      32'h0,   0, 1);
    for (int j = 0; j < 4; j++)
      add(0, 32'h0,     1, 32'h00010001, 0, 2'b00, 2'b11, 32'h00000001, 32'h20C, 32'h20E, 0, 1, 32'h0001,   32'h20E, 0, (j < 3));
    add(0, 32'h0,       1, 32'h55555555, 0, 2'b00, 2'b11, 32'h00000001, 32'h20C, 32'h20E, 0, 1, 32'h0001,   32'h20E, 0, 0);
    add(0, 32'h0,       0, 32'h0,        0, 2'b11, 2'b11, 32'h00000001, 32'h210, 32'h212, 0, 1, 32'h0001,   32'h212, 0, 1);
    add(0, 32'h0,       0, 32'h0,        0, 2'b11, 2'b11, 32'h00000001, 32'h214, 32'h216, 0, 1, 32'h0001,   32'h216, 0, 1);
    add(0, 32'h0,       0, 32'h0,        0, 2'b11, 2'b11, 32'h00000001, 32'h218, 32'h21A, 0, 1, 32'h0001,   32'h21A, 0, 1);
    add(0, 32'h0,       0, 32'h0,        0, 2'b11, 2'b00, 32'h0,        32'h21C, 32'h0,   0, 0, 32'h0,      32'h0,   0, 1);

    idle();
    repeat (2) @(posedge clock);
    #1;
    bus.fetch_valid = 1'b1;
    #1;
    chk("rst_ready", {31'h0, bus.fetch_ready}, 32'h0);
    chk("rst_valid", {30'h0, bus.instr_valid}, 32'h0);
    chk("rst_pc", bus.instr_pc[31:0], 32'h0);
    idle();
    reset = 1'b1;
    #1;
    chk("rel_ready", {31'h0, bus.fetch_ready}, 32'h1);
    chk("rel_valid", {30'h0, bus.instr_valid}, 32'h0);

    foreach (vq[i]) begin
      bus.clear       = vq[i].clr;
      bus.clear_pc    = vq[i].cpc;
      bus.fetch_valid = vq[i].fv;
      bus.fetch_data  = vq[i].fd;
      bus.fetch_error = vq[i].fe;
      bus.take        = vq[i].tk;
      @(posedge clock);
      #1;
      idle();
      #1;
      chk($sformatf("v%0d_valid", i), {30'h0, bus.instr_valid}, {30'h0, vq[i].ev});
      chk($sformatf("v%0d_pc0", i), bus.instr_pc[31:0], vq[i].ep0);
      chk($sformatf("v%0d_ready", i), {31'h0, bus.fetch_ready}, {31'h0, vq[i].er});
      if (vq[i].ev[0]) begin
        chk($sformatf("v%0d_npc0", i), bus.instr_npc[31:0], vq[i].en0);
        chk($sformatf("v%0d_err0", i), {31'h0, bus.instr_error[0]}, {31'h0, vq[i].ee0});
        if (vq[i].ci0) chk($sformatf("v%0d_instr0", i), bus.instr[31:0], vq[i].ei0);
      end
      if (vq[i].ev[1]) begin
        chk($sformatf("v%0d_instr1", i), bus.instr[63:32], vq[i].ei1);
        chk($sformatf("v%0d_pc1", i), bus.instr_pc[63:32], vq[i].ep1);
        chk($sformatf("v%0d_err1", i), {31'h0, bus.instr_error[1]}, {31'h0, vq[i].ee1});
      end
    end

    // Clear holds fetch_ready low combinationally and drops the offered beat.
    bus.clear       = 1'b1;
    bus.clear_pc    = 32'h0000_0300;
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 32'h12345678;
    #1;
    chk("clr_ready_low", {31'h0, bus.fetch_ready}, 32'h0);
    @(posedge clock);
    #1;
    idle();
    #1;
    chk("clr_pc", bus.instr_pc[31:0], 32'h300);
    chk("clr_valid", {30'h0, bus.instr_valid}, 32'h0);

    // Asynchronous reset mid-operation.
    beat(32'h00010001);
    chk("pre_rst_valid", {30'h0, bus.instr_valid}, 32'h3);
    chk("pre_rst_pc", bus.instr_pc[31:0], 32'h300);
    reset = 1'b0;
    #1;
    chk("async_rst_valid", {30'h0, bus.instr_valid}, 32'h0);
    chk("async_rst_ready", {31'h0, bus.fetch_ready}, 32'h0);
    chk("async_rst_pc", bus.instr_pc[31:0], 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("post_rst_ready", {31'h0, bus.fetch_ready}, 32'h1);
    chk("post_rst_valid", {30'h0, bus.instr_valid}, 32'h0);

    // Compressed pair from the reset PC.
    beat(32'h45014081);
    chk("pair_valid", {30'h0, bus.instr_valid}, 32'h3);
    chk("pair_instr0", bus.instr[31:0], 32'h00004081);
    chk("pair_pc0", bus.instr_pc[31:0], 32'h0);
    chk("pair_npc0", bus.instr_npc[31:0], 32'h2);
    chk("pair_instr1", bus.instr[63:32], 32'h00004501);
    chk("pair_pc1", bus.instr_pc[63:32], 32'h2);
    chk("pair_npc1", bus.instr_npc[63:32], 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
